// File: rtl/pixel_uart_tx.sv
`default_nettype none
// ============================================================================
// Module  : pixel_uart_tx
// Brief   : Drains RGB pixels from a req/ack frame buffer port and sends each
//           one as three 8N1 UART bytes (R, G, B) on a single TX line.
// Rev     : 1.0
// ============================================================================
module pixel_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int NUM_PIXELS   = 16384
) (
    input  logic        clk,
    input  logic        xrst,
    input  logic        start,
    input  logic [23:0] pixel_in,
    output logic        snd_req,
    input  logic        snd_ack,
    output logic        uart_txd,
    output logic        busy,
    output logic        frame_done
);

    localparam int c_BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_PIX_W  = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_PIX_W-1:0]  c_PIX_LAST  = c_PIX_W'(NUM_PIXELS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t                r_state;
    logic [23:0]           r_shreg;
    logic [1:0]            r_byte_idx;
    logic [2:0]            r_bit_idx;
    logic [c_BAUD_W-1:0]   r_baud;
    logic [c_PIX_W-1:0]    r_pix_cnt;
    logic                  r_snd_req;
    logic                  r_txd;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_bit_end;
    logic [7:0]            w_cur_byte;

    // The byte on the wire is always the top byte; the register shifts left per byte.
    assign w_cur_byte = r_shreg[23:16];
    assign w_bit_end  = (r_baud == c_BAUD_LAST);

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_state    <= S_IDLE;
            r_shreg    <= '0;
            r_byte_idx <= '0;
            r_bit_idx  <= '0;
            r_baud     <= '0;
            r_pix_cnt  <= '0;
            r_snd_req  <= 1'b0;
            r_txd      <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A start coinciding with the frame_done pulse is deliberately dropped.
                    if (start && !r_done) begin
                        r_busy    <= 1'b1;
                        r_snd_req <= 1'b1;
                        r_pix_cnt <= '0;
                        r_state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (snd_ack) begin
                        r_shreg    <= pixel_in;
                        r_byte_idx <= '0;
                        r_snd_req  <= 1'b0;
                        r_txd      <= 1'b0;
                        r_baud     <= '0;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_txd     <= w_cur_byte[0];
                        r_state   <= S_DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_txd   <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_txd     <= w_cur_byte[r_bit_idx + 3'd1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (r_byte_idx != 2'd2) begin
                            r_byte_idx <= r_byte_idx + 2'd1;
                            r_shreg    <= {r_shreg[15:0], 8'h00};
                            r_txd      <= 1'b0;
                            r_state    <= S_START;
                        end else if (r_pix_cnt != c_PIX_LAST) begin
                            r_pix_cnt <= r_pix_cnt + 1'b1;
                            r_snd_req <= 1'b1;
                            r_state   <= S_REQ;
                        end else begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign snd_req    = r_snd_req;
    assign uart_txd   = r_txd;
    assign busy       = r_busy;
    assign frame_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pixel_uart_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_pixel_uart_tx
// Brief   : Directed self-checking bench for pixel_uart_tx (three instances:
//           CPB=4/N=2, CPB=4/N=1, CPB=868/N=1).
// Rev     : 1.0
// ============================================================================
module tb_pixel_uart_tx;

    logic        clk  = 1'b0;
    logic        xrst = 1'b0;
    logic [2:0]  start_v = '0;
    logic [2:0]  ack_v   = '0;
    logic [23:0] pix_v [3];
    wire  [2:0]  req_v, txd_v, busy_v, done_v;

    int checks   = 0;
    int failures = 0;
    bit samp [32768];

    always #5 clk = ~clk;

    pixel_uart_tx #(.CLKS_PER_BIT(4), .NUM_PIXELS(2)) u_dut_n2 (
        .clk(clk), .xrst(xrst), .start(start_v[0]), .pixel_in(pix_v[0]),
        .snd_req(req_v[0]), .snd_ack(ack_v[0]), .uart_txd(txd_v[0]),
        .busy(busy_v[0]), .frame_done(done_v[0]));

    pixel_uart_tx #(.CLKS_PER_BIT(4), .NUM_PIXELS(1)) u_dut_n1 (
        .clk(clk), .xrst(xrst), .start(start_v[1]), .pixel_in(pix_v[1]),
        .snd_req(req_v[1]), .snd_ack(ack_v[1]), .uart_txd(txd_v[1]),
        .busy(busy_v[1]), .frame_done(done_v[1]));

    pixel_uart_tx #(.CLKS_PER_BIT(868), .NUM_PIXELS(1)) u_dut_baud (
        .clk(clk), .xrst(xrst), .start(start_v[2]), .pixel_in(pix_v[2]),
        .snd_req(req_v[2]), .snd_ack(ack_v[2]), .uart_txd(txd_v[2]),
        .busy(busy_v[2]), .frame_done(done_v[2]));

    function automatic logic [7:0] dec_byte(input int base, input int cpb);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = samp[base + (1 + i) * cpb + cpb / 2];
        return b;
    endfunction

    function automatic bit framing_ok(input int base, input int cpb);
        return (samp[base + cpb / 2] == 1'b0) && (samp[base + 9 * cpb + cpb / 2] == 1'b1);
    endfunction

    function automatic logic [23:0] dec_pixel(input int base);
        return {dec_byte(base, 4), dec_byte(base + 40, 4), dec_byte(base + 80, 4)};
    endfunction

    task automatic do_start(input int k);
        @(negedge clk); start_v[k] = 1'b1;
        @(negedge clk); start_v[k] = 1'b0;
    endtask

    task automatic ack_after(input int k, input int dly, input logic [23:0] px,
                             output int txd_low, output int req_low);
        txd_low = 0; req_low = 0;
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            if (txd_v[k] !== 1'b1) txd_low++;
            if (req_v[k] !== 1'b1) req_low++;
        end
        ack_v[k] = 1'b1;
        pix_v[k] = px;
    endtask

    // Samples the line for n cycles after an ack; optionally injects a stray ack+start at cycle inj.
    task automatic record(input int k, input int n, input int inj,
                          output int done_cnt, output int bad_cnt);
        done_cnt = 0; bad_cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0 || i == inj + 1) begin
                ack_v[k] = 1'b0; start_v[k] = 1'b0; pix_v[k] = '0;
            end
            if (i == inj) begin
                ack_v[k] = 1'b1; start_v[k] = 1'b1; pix_v[k] = 24'hFFFFFF;
            end
            samp[i] = txd_v[k];
            if (done_v[k] !== 1'b0) done_cnt++;
            if (busy_v[k] !== 1'b1 || req_v[k] !== 1'b0) bad_cnt++;
        end
    endtask

    task automatic test_reset();
        int errs;
        repeat (3) @(negedge clk);
        checks++; if (txd_v[0] !== 1'b1) begin failures++; $display("FAIL rst_txd: got %b expected 1", txd_v[0]); end
        checks++; if (req_v[0] !== 1'b0) begin failures++; $display("FAIL rst_req: got %b expected 0", req_v[0]); end
        checks++; if (busy_v[0] !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", busy_v[0]); end
        checks++; if (done_v[0] !== 1'b0) begin failures++; $display("FAIL rst_done: got %b expected 0", done_v[0]); end
        xrst = 1'b1;
        errs = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (txd_v !== 3'b111 || req_v !== 3'b000 || busy_v !== 3'b000 || done_v !== 3'b000) errs++;
        end
        checks++; if (errs !== 0) begin failures++; $display("FAIL idle_50: bad cycles %0d expected 0", errs); end
    endtask

    task automatic test_single_pixel();
        int tl, rl, dc, bc, extra;
        do_start(1);
        checks++; if (busy_v[1] !== 1'b1 || req_v[1] !== 1'b1) begin failures++; $display("FAIL sp_accept: busy=%b req=%b expected 1 1", busy_v[1], req_v[1]); end
        ack_after(1, 2, 24'hA53C0F, tl, rl);
        checks++; if (tl !== 0 || rl !== 0) begin failures++; $display("FAIL sp_wait: txd_low=%0d req_low=%0d expected 0 0", tl, rl); end
        record(1, 120, -1, dc, bc);
        checks++; if (samp[0] !== 1'b0) begin failures++; $display("FAIL sp_first_start: got %b expected 0", samp[0]); end
        checks++; if (dc !== 0 || bc !== 0) begin failures++; $display("FAIL sp_line: early_done=%0d bad=%0d expected 0 0", dc, bc); end
        checks++; if (dec_pixel(0) !== 24'hA53C0F) begin failures++; $display("FAIL sp_bytes: got %h expected a53c0f", dec_pixel(0)); end
        checks++; if (!(framing_ok(0, 4) && framing_ok(40, 4) && framing_ok(80, 4))) begin failures++; $display("FAIL sp_framing: got bad expected ok"); end
        @(negedge clk);
        checks++; if (done_v[1] !== 1'b1 || busy_v[1] !== 1'b0) begin failures++; $display("FAIL sp_done: done=%b busy=%b expected 1 0", done_v[1], busy_v[1]); end
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done_v[1] !== 1'b0 || req_v[1] !== 1'b0 || txd_v[1] !== 1'b1) extra++;
        end
        checks++; if (extra !== 0) begin failures++; $display("FAIL sp_after: bad cycles %0d expected 0", extra); end
    endtask

    task automatic test_frame_two_delayed();
        int tl, rl, dc, bc;
        do_start(0);
        ack_after(0, 0, 24'h123456, tl, rl);
        record(0, 120, -1, dc, bc);
        checks++; if (dec_pixel(0) !== 24'h123456) begin failures++; $display("FAIL f2_p1: got %h expected 123456", dec_pixel(0)); end
        checks++; if (dc !== 0 || bc !== 0) begin failures++; $display("FAIL f2_line1: done=%0d bad=%0d expected 0 0", dc, bc); end
        @(negedge clk);
        checks++; if (req_v[0] !== 1'b1 || txd_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin failures++; $display("FAIL f2_req2: req=%b txd=%b done=%b expected 1 1 0", req_v[0], txd_v[0], done_v[0]); end
        ack_after(0, 10, 24'hC3817E, tl, rl);
        checks++; if (tl !== 0 || rl !== 0) begin failures++; $display("FAIL f2_wait: txd_low=%0d req_low=%0d expected 0 0", tl, rl); end
        record(0, 120, -1, dc, bc);
        checks++; if (dec_pixel(0) !== 24'hC3817E) begin failures++; $display("FAIL f2_p2: got %h expected c3817e", dec_pixel(0)); end
        checks++; if (!(framing_ok(0, 4) && framing_ok(40, 4) && framing_ok(80, 4))) begin failures++; $display("FAIL f2_framing: got bad expected ok"); end
        @(negedge clk);
        checks++; if (done_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin failures++; $display("FAIL f2_done: done=%b busy=%b expected 1 0", done_v[0], busy_v[0]); end
        @(negedge clk);
        checks++; if (done_v[0] !== 1'b0) begin failures++; $display("FAIL f2_pulse: got %b expected 0", done_v[0]); end
    endtask

    task automatic test_spurious();
        int tl, rl, dc, bc, extra;
        do_start(0);
        ack_after(0, 0, 24'h0FF05A, tl, rl);
        record(0, 120, 20, dc, bc);
        checks++; if (dec_pixel(0) !== 24'h0FF05A) begin failures++; $display("FAIL sx_p1: got %h expected 0ff05a", dec_pixel(0)); end
        checks++; if (dc !== 0 || bc !== 0) begin failures++; $display("FAIL sx_line1: done=%0d bad=%0d expected 0 0", dc, bc); end
        @(negedge clk);
        checks++; if (req_v[0] !== 1'b1) begin failures++; $display("FAIL sx_req2: got %b expected 1", req_v[0]); end
        ack_after(0, 1, 24'h814224, tl, rl);
        record(0, 120, 100, dc, bc);
        checks++; if (dec_pixel(0) !== 24'h814224) begin failures++; $display("FAIL sx_p2: got %h expected 814224", dec_pixel(0)); end
        @(negedge clk);
        checks++; if (done_v[0] !== 1'b1) begin failures++; $display("FAIL sx_done: got %b expected 1", done_v[0]); end
        extra = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (req_v[0] !== 1'b0 || txd_v[0] !== 1'b1 || busy_v[0] !== 1'b0) extra++;
        end
        checks++; if (extra !== 0) begin failures++; $display("FAIL sx_no_restart: bad cycles %0d expected 0", extra); end
    endtask

    task automatic test_reset_midop();
        int tl, rl, dc, bc;
        do_start(0);
        ack_after(0, 0, 24'hFF00FF, tl, rl);
        record(0, 50, -1, dc, bc);
        #1;
        checks++; if (txd_v[0] !== 1'b0 || busy_v[0] !== 1'b1) begin failures++; $display("FAIL mr_pre: txd=%b busy=%b expected 0 1", txd_v[0], busy_v[0]); end
        xrst = 1'b0;
        #1;
        checks++; if (txd_v[0] !== 1'b1) begin failures++; $display("FAIL mr_txd_async: got %b expected 1", txd_v[0]); end
        checks++; if (req_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin failures++; $display("FAIL mr_req_busy: req=%b busy=%b expected 0 0", req_v[0], busy_v[0]); end
        repeat (2) @(negedge clk);
        xrst = 1'b1;
        do_start(0);
        ack_after(0, 0, 24'h3CA596, tl, rl);
        record(0, 120, -1, dc, bc);
        checks++; if (dec_pixel(0) !== 24'h3CA596) begin failures++; $display("FAIL mr_p1: got %h expected 3ca596", dec_pixel(0)); end
        @(negedge clk);
        ack_after(0, 2, 24'h01807F, tl, rl);
        record(0, 120, -1, dc, bc);
        checks++; if (dec_pixel(0) !== 24'h01807F) begin failures++; $display("FAIL mr_p2: got %h expected 01807f", dec_pixel(0)); end
        @(negedge clk);
        checks++; if (done_v[0] !== 1'b1) begin failures++; $display("FAIL mr_done: got %b expected 1", done_v[0]); end
    endtask

    task automatic test_baud();
        int  tl, rl, len, nseg, bad, first_bad;
        bit  got_done;
        logic prev;
        do_start(2);
        ack_after(2, 0, 24'h555555, tl, rl);
        prev = 1'b0; len = 0; nseg = 0; bad = 0; first_bad = -1; got_done = 1'b0;
        for (int i = 0; i < 30 * 868 + 20 && !got_done; i++) begin
            @(negedge clk);
            if (i == 0) begin ack_v[2] = 1'b0; pix_v[2] = '0; end
            if (done_v[2] === 1'b1) begin
                got_done = 1'b1;
                nseg++;
                if (len != 868) begin bad++; if (first_bad < 0) first_bad = len; end
            end else if (txd_v[2] !== prev) begin
                nseg++;
                if (len != 868) begin bad++; if (first_bad < 0) first_bad = len; end
                prev = txd_v[2];
                len  = 1;
            end else begin
                len++;
            end
        end
        checks++; if (got_done !== 1'b1) begin failures++; $display("FAIL bd_done: got %b expected 1 (timeout)", got_done); end
        checks++; if (nseg !== 30) begin failures++; $display("FAIL bd_segments: got %0d expected 30", nseg); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL bd_width: %0d bad segments, first len %0d expected 868", bad, first_bad); end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) pix_v[k] = '0;
        test_reset();
        test_single_pixel();
        test_frame_two_delayed();
        test_spurious();
        test_reset_midop();
        test_baud();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
